// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with blocking request/ready refill.
// Define ICACHE_STATS_EN to build saturating hit/miss counters.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                req,
    input  logic [31:0]         addr,
    input  logic                flush,
    output logic [31:0]         rdata,
    output logic                hit,
    output logic                stall,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic [32*WORDS-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    localparam int IB = $clog2(LINES);
    localparam int OB = $clog2(WORDS) + 2;
    localparam int TB = 32 - OB - IB;

    typedef enum logic {IDLE, MISS} state_t;

    state_t              r_state, w_next;
    logic [LINES-1:0]    r_valid;
    logic [TB-1:0]       r_tag  [LINES];
    logic [32*WORDS-1:0] r_data [LINES];
    logic                r_mem_req;
    logic [31-OB:0]      r_mem_blk;

    logic [IB-1:0]       w_idx, w_fidx;
    logic [TB-1:0]       w_tag, w_ftag;
    logic [OB-1:0]       w_woff;
    logic [32*WORDS-1:0] w_line;
    logic                w_hit, w_fill, w_start;

    assign w_idx   = addr[OB+IB-1:OB];
    assign w_tag   = addr[31:OB+IB];
    assign w_woff  = addr[OB-1:0] >> 2;
    assign w_line  = r_data[w_idx];
    assign w_fidx  = r_mem_blk[IB-1:0];
    assign w_ftag  = r_mem_blk[31-OB:IB];
    assign w_hit   = req && r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_state == IDLE);
    assign w_fill  = (r_state == MISS) && mem_ready;
    assign w_start = (r_state == IDLE) && (w_next == MISS);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = (req && !w_hit) ? MISS : IDLE;
        else                 w_next = mem_ready ? IDLE : MISS;
    end

    always_comb begin
        hit      = w_hit;
        rdata    = w_hit ? w_line[{w_woff, 5'b0} +: 32] : 32'd0;
        stall    = (r_state == MISS) || (req && !w_hit);
        mem_req  = r_mem_req;
        mem_addr = {r_mem_blk, {OB{1'b0}}};
    end

    // The request address is latched only on the IDLE->MISS edge, so addr may wander during a fill.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_mem_req <= 1'b0;
            r_mem_blk <= '0;
        end else begin
            r_mem_req <= (w_next == MISS);
            if (w_start) r_mem_blk <= addr[31:OB];
        end
    end

    // Flush takes priority over a coinciding fill so the filled line stays invalid.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)         r_valid <= '0;
        else if (flush)  r_valid <= '0;
        else if (w_fill) r_valid[w_fidx] <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && r_hit_count != '1)    r_hit_count  <= r_hit_count + 32'd1;
            if (w_start && r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed checks of icache_dm with LINES=16, WORDS=4.
module tb_icache_dm;
`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [127:0] BLK1 = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'hA0A0A0A0};
    localparam logic [127:0] BLK2 = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};

    logic         Clk = 1'b0;
    logic         Rst, req, flush, mem_ready;
    logic [31:0]  addr, rdata, mem_addr, hit_count, miss_count;
    logic         hit, stall, mem_req;
    logic [127:0] mem_rdata;
    int           n_checks = 0;
    int           n_fail = 0;

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .addr(addr), .flush(flush),
        .rdata(rdata), .hit(hit), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; req = 1'b0; addr = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        #12 Rst = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misses", miss_count, 32'd0);
        cyc(); req = 1'b1; addr = 32'h1004; #1;
        check("cold_stall", 32'(stall), 32'd1);
        check("cold_hit", 32'(hit), 32'd0);
        cyc(); #1;
        check("cold_mem_req", 32'(mem_req), 32'd1);
        check("cold_mem_addr", mem_addr, 32'h1000);
        check("cold_miss_rdata", rdata, 32'd0);
        cyc(); #1;
        check("cold_wait_req", 32'(mem_req), 32'd1);
        cyc(); mem_ready = 1'b1; mem_rdata = BLK1; #1;
        check("cold_fill_stall", 32'(stall), 32'd1);
        cyc(); mem_ready = 1'b0; mem_rdata = '0; #1;
        check("cold_hit_after", 32'(hit), 32'd1);
        check("cold_rdata", rdata, 32'hDEADBEEF);
        check("cold_stall_clr", 32'(stall), 32'd0);
        check("cold_req_clr", 32'(mem_req), 32'd0);
        check("cold_misses", miss_count, STATS ? 32'd1 : 32'd0);
        check("cold_hits", hit_count, 32'd0);
        cyc(); addr = 32'h1000; #1;
        check("w0_rdata", rdata, 32'hA0A0A0A0);
        check("w0_hits", hit_count, STATS ? 32'd1 : 32'd0);
        cyc(); addr = 32'h1008; #1;
        check("w2_rdata", rdata, 32'h22222222);
        check("w2_stall", 32'(stall), 32'd0);
        check("w2_hits", hit_count, STATS ? 32'd2 : 32'd0);
        cyc(); addr = 32'h100F; #1;
        check("w3_rdata", rdata, 32'h33333333);
        check("w3_hits", hit_count, STATS ? 32'd3 : 32'd0);
        cyc(); addr = 32'h2000; #1;
        check("conf_hit", 32'(hit), 32'd0);
        check("conf_stall", 32'(stall), 32'd1);
        check("conf_hits", hit_count, STATS ? 32'd4 : 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 4) addr = 32'h3040;
            #1;
            check("slow_mem_req", 32'(mem_req), 32'd1);
            check("slow_mem_addr", mem_addr, 32'h2000);
            check("slow_stall", 32'(stall), 32'd1);
            check("slow_hit", 32'(hit), 32'd0);
            if (i == 0) check("conf_misses", miss_count, STATS ? 32'd2 : 32'd0);
        end
        cyc(); mem_ready = 1'b1; mem_rdata = BLK2; addr = 32'h2004; #1;
        check("slow_fill_req", 32'(mem_req), 32'd1);
        cyc(); mem_ready = 1'b0; mem_rdata = '0; #1;
        check("conf_fill_hit", 32'(hit), 32'd1);
        check("conf_fill_rdata", rdata, 32'h66666666);
        cyc(); addr = 32'h1000; #1;
        check("evict_hit", 32'(hit), 32'd0);
        check("evict_stall", 32'(stall), 32'd1);
        cyc(); #1;
        check("evict_mem_addr", mem_addr, 32'h1000);
        mem_ready = 1'b1; flush = 1'b1; mem_rdata = BLK1;
        cyc(); mem_ready = 1'b0; flush = 1'b0; mem_rdata = '0; #1;
        check("flushfill_req", 32'(mem_req), 32'd0);
        check("flushfill_hit", 32'(hit), 32'd0);
        check("flushfill_stall", 32'(stall), 32'd1);
        cyc(); #1;
        check("refill_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = BLK1;
        cyc(); mem_ready = 1'b0; mem_rdata = '0; #1;
        check("refill_hit", 32'(hit), 32'd1);
        check("refill_rdata", rdata, 32'hA0A0A0A0);
        cyc(); req = 1'b0; flush = 1'b1; #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_hit", 32'(hit), 32'd0);
        cyc(); flush = 1'b0; req = 1'b1; #1;
        check("flush_hit", 32'(hit), 32'd0);
        check("flush_stall", 32'(stall), 32'd1);
        cyc(); #1;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 Rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_hits", hit_count, 32'd0);
        check("rst_mid_misses", miss_count, 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd1);
        cyc(); Rst = 1'b0; addr = 32'h2004; #1;
        check("post_rst_hit", 32'(hit), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd1);
        cyc(); #1;
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", mem_addr, 32'h2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache between the fetch stage and the instruction memory. It supports configurable line count and block size, and performs a combinational hit lookup. Misses raise a stall and run a request/ready block refill. A flush invalidates the whole cache. Optional hit/miss statistics counters can be compiled in.

## Interface
- LINES, 16, number of cache lines; power of 2, ≥2; IB = log2(LINES)
- WORDS, 4, 32-bit words per block; power of 2, 1..8; OB = log2(WORDS)+2
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- req  in  1  fetch request valid this cycle
- addr  in  32  fetch byte address; offset [OB-1:0], index [OB+IB-1:OB], tag [31:OB+IB]
- flush  in  1  invalidate all lines at next rising edge
- rdata  out  32  fetched word; valid when hit=1, else 0
- hit  out  1  req & valid[index] & tag match & state==IDLE (combinational)
- stall  out  1  fetch must hold addr and retry
- mem_req  out  1  refill request, registered
- mem_addr  out  32  block-aligned refill address (low OB bits 0), registered
- mem_rdata  in  32*WORDS  refill block; word w at bits [32w+31:32w]
- mem_ready  in  1  mem_rdata valid this cycle
- hit_count  out  32  hits (see Configuration)
- miss_count  out  32  misses (see Configuration)

## Operation
- Storage: per line a valid bit, a tag of 32-OB-IB bits, and a 32*WORDS-bit data field.
- Word select: rdata = line data word addr[OB-1:2]. addr[1:0] is ignored.
- States: IDLE and MISS.
- IDLE:
  - req=1 & hit=1: rdata is returned in the same cycle and stall=0.
  - req=1 & hit=0: stall=1. At the next edge, mem_addr <= {addr[31:OB],0} and mem_req <= 1, and the state goes to MISS.
  - req=0: no action, and stall=0.
- MISS:
  - stall=1, hit=0, rdata=0.
  - mem_req stays high and mem_addr stays stable until mem_ready is sampled high.
  - At that edge: write data, tag and valid=1 to the line indexed by mem_addr, set mem_req <= 0, and return to IDLE.
- mem_ready is ignored in IDLE.
- If addr changes during MISS, the fill still completes for the latched mem_addr. The new addr is looked up in IDLE afterwards.
- Flush:
  - At the edge where flush=1, all valid bits are cleared.
  - Flush does not abort an outstanding MISS; the fill still installs its line.
  - If flush and fill completion hit the same edge, flush wins and the filled line stays invalid.
- Reset: all valid bits 0, state IDLE, mem_req 0, mem_addr 0, counters 0. It takes effect immediately and aborts any MISS.

## Timing
- Hit latency: 0 cycles, since rdata and hit are combinational from addr.
- Miss: detected in cycle 0, mem_req high from cycle 1. If mem_ready is high in cycle k, the line is written at the end of cycle k. The retried req hits in cycle k+1.
- Minimum miss penalty: 2 cycles (mem_ready already high in cycle 1).
- One outstanding refill at most; no back-to-back mem_req without an intervening IDLE cycle.
- Outputs after reset release: mem_req=0, mem_addr=0, hit=0, rdata=0. stall=req, because every line is invalid.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments on every IDLE cycle with req & hit.
  - miss_count increments on each IDLE→MISS transition.
  - Both counters are 32-bit and saturate at 32'hFFFFFFFF. Both clear on Rst; flush does not clear them.
- ICACHE_STATS_EN undefined: hit_count and miss_count are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
All scenarios use LINES=16 and WORDS=4.
- Cold miss: after Rst, req=1 with addr=0x00001004. Require stall=1 and mem_req=1 next cycle with mem_addr=0x00001000. Drive mem_rdata word1=0xDEADBEEF with mem_ready=1 at cycle 3. Require hit=1, rdata=0xDEADBEEF at cycle 4, and miss_count=1.
- Same-block hits: after the fill, addr=0x1000, 0x1008, 0x100C. Require hit=1, stall=0 each cycle with words 0/2/3 returned. hit_count increments by 1 per cycle with stats enabled.
- Conflict eviction: fill 0x1000, then access 0x2000 (same index 0, different tag). Require a miss and refill. A later access to 0x1000 misses again.
- Stalled memory: mem_ready held 0 for 10 cycles in MISS. Require mem_req=1 and mem_addr stable throughout, and no line written. Changing addr mid-MISS does not alter mem_addr.
- Flush: with a valid line, assert flush for 1 cycle, then access it. Require a miss. Flush coincident with mem_ready: the line stays invalid and the next access misses.
- Reset mid-MISS: assert Rst while mem_req=1. Require mem_req=0 immediately, state IDLE, counters 0, and all accesses miss.
